// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and cache-fill controller.
// Detects load-use hazards, sequences I/D cache fills over one shared memory
// port, handles taken-branch flushes and halt, and counts stalled cycles.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | normal issue; hazards and misses resolved combinationally
// DFILL | D-cache fill in flight, whole pipeline frozen
// IFILL | I-cache fill in flight, fetch held, IF/ID fed with NOPs
// HALT  | HLT retired into ID; frozen until reset
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_IDEX,
    input  logic [3:0]  DstReg_IDEX,
    input  logic [3:0]  SrcReg1_IFID,
    input  logic [3:0]  SrcReg2_IFID,
    input  logic        Src1_used,
    input  logic        Src2_used,
    input  logic        Branch_taken_ID,
    input  logic        Halt_ID,
    input  logic        icache_miss,
    input  logic        dcache_miss,
    input  logic        mem_done,
    output logic        mem_req,
    output logic        mem_sel,
    output logic        PC_we,
    output logic        IFID_we,
    output logic        IFID_flush,
    output logic        IDEX_we,
    output logic        IDEX_bubble,
    output logic        EXMEM_we,
    output logic        MEMWB_bubble,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, DFILL, IFILL, HALT} state_t;

    state_t state;
    state_t state_nxt;
    logic   luh;

    // r0 is hardwired zero, so a load targeting it never creates a hazard.
    assign luh = MemRead_IDEX && (DstReg_IDEX != 4'd0) &&
                 ((Src1_used && (DstReg_IDEX == SrcReg1_IFID)) ||
                  (Src2_used && (DstReg_IDEX == SrcReg2_IFID)));

    // Next-state and pipeline control; outputs react in the same cycle as the hazard.
    always_comb begin
        state_nxt    = state;
        mem_req      = 1'b0;
        mem_sel      = 1'b0;
        PC_we        = 1'b1;
        IFID_we      = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_we      = 1'b1;
        IDEX_bubble  = 1'b0;
        EXMEM_we     = 1'b1;
        MEMWB_bubble = 1'b0;
        halted       = 1'b0;
        case (state)
            RUN: begin
                if (dcache_miss) begin
                    PC_we        = 1'b0;
                    IFID_we      = 1'b0;
                    IDEX_we      = 1'b0;
                    EXMEM_we     = 1'b0;
                    MEMWB_bubble = 1'b1;
                    state_nxt    = DFILL;
                end else if (icache_miss) begin
                    PC_we      = 1'b0;
                    IFID_flush = 1'b1;
                    state_nxt  = IFILL;
                end else if (luh) begin
                    // Branch is deliberately ignored: the stalled ID instruction re-resolves it.
                    PC_we       = 1'b0;
                    IFID_we     = 1'b0;
                    IDEX_bubble = 1'b1;
                end else begin
                    IFID_flush = Branch_taken_ID;
                    if (Halt_ID) begin
                        state_nxt = HALT;
                    end
                end
            end
            DFILL: begin
                mem_req      = 1'b1;
                mem_sel      = 1'b1;
                PC_we        = 1'b0;
                IFID_we      = 1'b0;
                IDEX_we      = 1'b0;
                EXMEM_we     = 1'b0;
                MEMWB_bubble = 1'b1;
                if (mem_done) begin
                    state_nxt = icache_miss ? IFILL : RUN;
                end
            end
            IFILL: begin
                mem_req    = 1'b1;
                PC_we      = 1'b0;
                IFID_flush = 1'b1;
                if (mem_done) begin
                    state_nxt = dcache_miss ? DFILL : RUN;
                end
            end
            default: begin
                PC_we       = 1'b0;
                IFID_we     = 1'b0;
                IDEX_bubble = 1'b1;
                halted      = 1'b1;
            end
        endcase
    end

    // State register; reset abandons any fill in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Saturating stall counter; halted cycles are not stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 16'd0;
        end else if (!PC_we && (state != HALT) && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule
